mul_datapath: RTL

- Shift-add multiplier datapath driven by the microcoded sequencer's `dp_ctrl` word.
- Executes one micro-operation per clock and returns the selected condition bit on `cres`, which the sequencer uses for conditional jumps.
- Holds operand, partial-product and iteration-count registers, and publishes the final product with a one-cycle `done` strobe.
- Sits beside the control unit in the PseudoCPU core. It is the consumer of `dp_ctrl` and the producer of `cres`.

---
 rtl/mul_datapath.sv | 67 ++++++
 1 files changed

// File: rtl/mul_datapath.sv
// mul_datapath: shift-add multiplier datapath. It executes one dp_ctrl
// micro-op per clock and reports a condition bit on cres so the sequencer
// can branch. The product is published on result with a one-cycle done strobe.
module mul_datapath #(
  parameter int P_WIDTH          = 8,
  parameter int P_NUM_D_CTRLBITS = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [P_NUM_D_CTRLBITS-1:0] dp_ctrl,
  input  logic [P_WIDTH-1:0]          a_in,
  input  logic [P_WIDTH-1:0]          b_in,
  output logic                        cres,
  output logic [2*P_WIDTH-1:0]        result,
  output logic                        done
);

  localparam int CW = $clog2(P_WIDTH + 1);

  logic [2*P_WIDTH-1:0] as_q;
  logic [P_WIDTH-1:0]   b_q;
  logic [2*P_WIDTH-1:0] p_q;
  logic [CW-1:0]        cnt_q;

  logic op_ld, op_add, op_shf, op_done, op_csel;
  assign op_ld   = dp_ctrl[0];
  assign op_add  = dp_ctrl[1];
  assign op_shf  = dp_ctrl[2];
  assign op_done = dp_ctrl[3];
  assign op_csel = dp_ctrl[4];

  // Condition bit for the sequencer. It has zero latency and reads the current registers.
  always_comb begin
    cres = op_csel ? (cnt_q == '0) : b_q[0];
  end

  // Micro-op execution. Every update is computed from the pre-edge register values.
  // LD wins over ADD and SHF. DONE is independent of the other bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      as_q   <= '0;
      b_q    <= '0;
      p_q    <= '0;
      cnt_q  <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      if (op_ld) begin
        as_q  <= {{P_WIDTH{1'b0}}, a_in};
        b_q   <= b_in;
        p_q   <= '0;
        cnt_q <= CW'(P_WIDTH);
      end else begin
        if (op_add) p_q <= p_q + as_q;
        if (op_shf) begin
          as_q  <= as_q << 1;
          b_q   <= b_q >> 1;
          // CNT saturates at zero so stray shifts cannot wrap the loop count.
          cnt_q <= (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        end
      end
      if (op_done) result <= p_q;
      done <= op_done;
    end
  end

endmodule
